// File: rtl/seq_divider16.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider16
//  Purpose  : Sequential unsigned divider, radix-2 restoring, one quotient
//             bit per clock. Operands are captured on an accepted start;
//             quotient, remainder and divide-by-zero flag are published
//             together with a one-cycle done pulse.
//  Ports    : clk        - clock, rising-edge active
//             rst_n      - asynchronous active-low reset
//             start      - divide request, honoured when not busy
//             Dividend   - unsigned dividend, captured on accepted start
//             Divisor    - unsigned divisor, captured on accepted start
//             busy       - division in progress
//             done       - one-cycle pulse, results valid and updated
//             Quotient   - registered quotient, held until next completion
//             Remainder  - registered remainder, held until next completion
//             DivByZero  - registered, set when the divisor was zero
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    // Partial remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only matters inside the trial subtraction below.
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  d;
    logic [CNT_W-1:0]  cnt;

    logic [WIDTH:0]    p_shift;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  p_next;
    logic [WIDTH-1:0]  q_next;
    logic              accept;
    logic              div_zero;
    logic              last_iter;

    assign accept    = start && (state != RUN);
    assign div_zero  = (Divisor == '0);
    assign last_iter = (state == RUN) && (cnt == LAST_ITER);

    // One restoring step: shift {P,Q} left, trial-subtract D, keep the
    // difference only when it did not go negative.
    assign p_shift = {p, q[WIDTH-1]};
    assign diff    = p_shift - {1'b0, d};
    assign p_next  = diff[WIDTH] ? p_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ~diff[WIDTH]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = div_zero ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                // Zero divisor skips the iteration entirely.
                Quotient  <= '1;
                Remainder <= Dividend;
                DivByZero <= 1'b1;
            end else begin
                q   <= Dividend;
                d   <= Divisor;
                p   <= '0;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            p   <= p_next;
            q   <= q_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                Quotient  <= q_next;
                Remainder <= p_next;
                DivByZero <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider16
//  Purpose  : Self-checking bench for seq_divider16 using directed vectors
//             with hand-computed results plus a short randomized sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    seq_divider16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Dividend  (dividend),
        .Divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .Quotient  (quotient),
        .Remainder (remainder),
        .DivByZero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Issue one division and follow it to completion. poke_at >= 0 pulses a
    // second start (7/7) that many cycles into the run; it must be ignored.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                           input int elat, input int poke_at);
        int lat;
        int busy_cnt;
        int overlap;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0001;
        lat      = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (poke_at >= 0 && lat == poke_at) begin
                start    = 1'b1;
                dividend = 16'd7;
                divisor  = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy && done) overlap = 1;
        check({tag, " done"},      {31'd0, done},        32'd1);
        check({tag, " latency"},   lat,                  elat);
        check({tag, " busy_cyc"},  busy_cnt,             elat);
        check({tag, " overlap"},   overlap,              32'd0);
        check({tag, " quotient"},  {16'd0, quotient},    {16'd0, eq});
        check({tag, " remainder"}, {16'd0, remainder},   {16'd0, er});
        check({tag, " dbz"},       {31'd0, div_by_zero}, {31'd0, edbz});
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done},       32'd0);
        check({tag, " hold_q"},    {16'd0, quotient},    {16'd0, eq});
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, busy},        32'd0);
        check("rst done", {31'd0, done},        32'd0);
        check("rst q",    {16'd0, quotient},    32'd0);
        check("rst r",    {16'd0, remainder},   32'd0);
        check("rst dbz",  {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("100/7",     16'd100,   16'd7,     16'd14,    16'd2,  1'b0, 16, -1);
        run_div("ffff/1",    16'hFFFF,  16'd1,     16'hFFFF,  16'd0,  1'b0, 16, -1);
        run_div("ffff/ffff", 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,  1'b0, 16, -1);
        run_div("3/10",      16'd3,     16'd10,    16'd0,     16'd3,  1'b0, 16, -1);
        run_div("5/0",       16'd5,     16'd0,     16'hFFFF,  16'd5,  1'b1, 0,  -1);
        run_div("9/3",       16'd9,     16'd3,     16'd3,     16'd0,  1'b0, 16, -1);
        run_div("1000/10",   16'd1000,  16'd10,    16'd100,   16'd0,  1'b0, 16, 5);

        // Asynchronous reset in the middle of 500/3.
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, busy},        32'd0);
        check("arst done", {31'd0, done},        32'd0);
        check("arst q",    {16'd0, quotient},    32'd0);
        check("arst r",    {16'd0, remainder},   32'd0);
        check("arst dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("500/3", 16'd500, 16'd3, 16'd166, 16'd2, 1'b0, 16, -1);

        // Back-to-back: start held high across the DONE cycle.
        @(negedge clk);
        dividend = 16'd60000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend = 16'd12;
        divisor  = 16'd5;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b first lat", lat,                32'd16);
        check("b2b first q",   {16'd0, quotient},  32'd8571);
        check("b2b first r",   {16'd0, remainder}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b spacing",  lat,                32'd17);
        check("b2b second q", {16'd0, quotient},  32'd2);
        check("b2b second r", {16'd0, remainder}, 32'd2);
        @(negedge clk);

        // Randomized sweep against the language operators.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            case (i % 4)
                0: rb = 16'($urandom_range(0, 15));
                1: rb = 16'($urandom_range(0, 255));
                default: rb = 16'($urandom);
            endcase
            if (rb == 16'd0)
                run_div("rand", ra, rb, 16'hFFFF, ra, 1'b1, 0, -1);
            else
                run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 16, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
